// File: rtl/mulred_feed_4057.sv
// Operand feeder for a Barrett reducer: a radix-2 shift-add multiply followed by one
// conditional subtraction of Q<<(W-1), so a valid product leaves in 2W-1 bits.
module mulred_feed_4057 #(
    parameter int Q = 4057,
    parameter int W = 12
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   op_x,
    input  logic [W-1:0]   op_y,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-2:0] dout_a,
    output logic           out_err,
    output logic [1:0]     dbg_state
);
    localparam int PW = 2 * W;
    localparam int OW = 2 * W - 1;
    localparam int CW = $clog2(W);
    localparam logic [W:0]    Q_W    = (W + 1)'(Q);
    localparam logic [PW-1:0] FOLD_K = PW'(Q) << (W - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready is high only in IDLE, out_valid only in HOLD, and a held result never changes.
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FOLD, S_HOLD} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_x;
    logic [W-1:0]  r_y;
    logic [PW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [OW-1:0] r_dout;
    logic          r_err;
    logic [PW-1:0] w_addend;
    logic [OW-1:0] w_fold;

    assign w_addend = {{W{1'b0}}, r_x} << r_cnt;
    // Subtracting in OW bits gives the same truncated result as a full-width subtract.
    assign w_fold = (r_acc >= FOLD_K) ? (r_acc[OW-1:0] - FOLD_K[OW-1:0]) : r_acc[OW-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_next = S_MUL;
            S_MUL:   if (r_cnt == CNT_LAST) w_next = S_FOLD;
            S_FOLD:  w_next = S_HOLD;
            S_HOLD:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_dout <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x   <= op_x;
                        r_y   <= op_y;
                        r_err <= ({1'b0, op_x} >= Q_W) | ({1'b0, op_y} >= Q_W);
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_MUL: begin
                    if (r_y[r_cnt]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
                end
                S_FOLD: begin
                    r_dout <= w_fold;
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_HOLD);
    assign dout_a    = r_dout;
    assign out_err   = r_err;
    assign dbg_state = r_state;

endmodule
